// File: rtl/panel_pkg.sv
// Shared constants and FSM encoding for the panel frame loader.
package panel_pkg;

  localparam int CHUNKS_PER_ROW  = 12;
  localparam int ROWS            = 16;
  localparam int BYTES_PER_CHUNK = 4;
  localparam int BYTES_PER_FRAME = CHUNKS_PER_ROW * ROWS * BYTES_PER_CHUNK;

  localparam logic [3:0] LAST_CHUNK = 4'(CHUNKS_PER_ROW - 1);
  localparam logic [3:0] LAST_ROW   = 4'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_e;

endpackage

// File: rtl/panel_frame_loader_byte_packer.sv
// Packs accepted bytes big-endian into 32-bit words; word_valid_o is high
// for the single cycle after the 4th byte of a group is accepted.
module byte_packer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] shift_q, shift_d;
  logic [31:0] word_q, word_d;
  logic        valid_q, valid_d;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clear_i) begin
      cnt_d   = 2'd0;
      shift_d = 24'd0;
    end else if (byte_valid_i) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = {shift_q[15:0], byte_data_i};
      // Stale bytes left in shift_q are fully shifted out by the next group.
      if (cnt_q == 2'd3) begin
        word_d  = {shift_q, byte_data_i};
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= 2'd0;
      shift_q <= 24'd0;
      word_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word_valid_o = valid_q;
  assign word_o       = word_q;

endmodule

// File: rtl/panel_frame_loader.sv
// Frames a host byte stream into row-RAM chunk writes: 16 rows x 12 chunks,
// chunk index counting down from 11 so stream byte 0 lands in chunk 11 [31:24].
module panel_frame_loader
  import panel_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        frame_start_i,
  input  logic [7:0]  byte_data_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic [31:0] chunk_data_o,
  output logic [3:0]  chunk_addr_o,
  output logic [3:0]  row_addr_o,
  output logic        chunk_write_enable_o,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic        frame_abort_o
);

  state_e     state_q, state_d;
  logic [3:0] chunk_q, chunk_d;
  logic [3:0] row_q, row_d;
  logic       abort_q, abort_d;
  logic       accept;
  logic       final_write;

  // A restart request blocks acceptance so no byte straddles two frames.
  assign byte_ready_o = (state_q == LOAD) && !frame_start_i;
  assign accept       = byte_valid_i && byte_ready_o;

  byte_packer u_packer (
    .clk_i        (clk_i),
    .rst_ni       (reset_n_i),
    .clear_i      (frame_start_i),
    .byte_valid_i (accept),
    .byte_data_i  (byte_data_i),
    .word_valid_o (chunk_write_enable_o),
    .word_o       (chunk_data_o)
  );

  assign final_write = chunk_write_enable_o && (row_q == LAST_ROW) && (chunk_q == 4'd0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (frame_start_i) state_d = LOAD;
      LOAD: begin
        if (frame_start_i)    state_d = LOAD;
        else if (final_write) state_d = DONE;
      end
      DONE: state_d = frame_start_i ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters hold at row 15 / chunk 0 after the final write; only a restart reloads them.
  always_comb begin
    chunk_d = chunk_q;
    row_d   = row_q;
    abort_d = frame_start_i && (state_q == LOAD);
    if (frame_start_i) begin
      chunk_d = LAST_CHUNK;
      row_d   = 4'd0;
    end else if (chunk_write_enable_o && !final_write) begin
      if (chunk_q == 4'd0) begin
        chunk_d = LAST_CHUNK;
        row_d   = row_q + 4'd1;
      end else begin
        chunk_d = chunk_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      chunk_q <= 4'd0;
      row_q   <= 4'd0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      chunk_q <= chunk_d;
      row_q   <= row_d;
      abort_q <= abort_d;
    end
  end

  assign chunk_addr_o  = chunk_q;
  assign row_addr_o    = row_q;
  assign busy_o        = (state_q == LOAD);
  assign frame_done_o  = (state_q == DONE);
  assign frame_abort_o = abort_q;

endmodule

// File: tb/tb_panel_frame_loader.sv
// Randomized and directed bench for panel_frame_loader against a frame-level byte model.
module tb_panel_frame_loader;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        frameStart = 1'b0;
  logic [7:0]  byteData = 8'd0;
  logic        byteValid = 1'b0;
  logic        byteReady;
  logic [31:0] chunkData;
  logic [3:0]  chunkAddr;
  logic [3:0]  rowAddr;
  logic        chunkWe;
  logic        busy;
  logic        frameDone;
  logic        frameAbort;

  panel_frame_loader dut (
    .clk_i                (clk),
    .reset_n_i            (resetN),
    .frame_start_i        (frameStart),
    .byte_data_i          (byteData),
    .byte_valid_i         (byteValid),
    .byte_ready_o         (byteReady),
    .chunk_data_o         (chunkData),
    .chunk_addr_o         (chunkAddr),
    .row_addr_o           (rowAddr),
    .chunk_write_enable_o (chunkWe),
    .busy_o               (busy),
    .frame_done_o         (frameDone),
    .frame_abort_o        (frameAbort)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  bit          inFrame;
  int          nBytes;
  logic [7:0]  frameBytes [0:1023];
  bit          expWe, expDone, expAbort, expBusy, lastWasFinal;
  logic [31:0] expData;
  int          expRow, expChunk;

  bit          logEnable = 1'b0;
  logic [31:0] logData[$];
  logic [3:0]  logRow[$];
  logic [3:0]  logChunk[$];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
  endtask

  task automatic modelReset();
    inFrame = 0; nBytes = 0; expWe = 0; expDone = 0;
    expAbort = 0; expBusy = 0; lastWasFinal = 0;
  endtask

  // Drives one cycle of inputs, advances the frame model and compares all outputs.
  task automatic applyStimulus(input bit fs, input bit v, input logic [7:0] d);
    bit expReady, accepted, finalNow;
    int w;
    frameStart = fs; byteValid = v; byteData = d;
    #1;
    expReady = inFrame && !fs;
    checkOutput("byte_ready", {31'd0, byteReady}, {31'd0, expReady});
    @(posedge clk);
    accepted = v && expReady;
    finalNow = lastWasFinal;
    expAbort = fs && inFrame;
    expDone  = finalNow && !fs;
    if (fs) begin
      inFrame = 1; nBytes = 0;
    end else if (finalNow) begin
      inFrame = 0;
    end
    expWe = 0; lastWasFinal = 0;
    if (accepted && nBytes < 1024) begin
      frameBytes[nBytes] = d;
      nBytes++;
      if (nBytes % 4 == 0 && nBytes <= 768) begin
        w        = nBytes / 4 - 1;
        expWe    = 1;
        expRow   = w / 12;
        expChunk = 11 - (w % 12);
        expData  = {frameBytes[nBytes-4], frameBytes[nBytes-3],
                    frameBytes[nBytes-2], frameBytes[nBytes-1]};
        lastWasFinal = (nBytes == 768);
      end
    end
    expBusy = inFrame;
    #1;
    checkOutput("write_enable", {31'd0, chunkWe}, {31'd0, expWe});
    checkOutput("busy", {31'd0, busy}, {31'd0, expBusy});
    checkOutput("frame_done", {31'd0, frameDone}, {31'd0, expDone});
    checkOutput("frame_abort", {31'd0, frameAbort}, {31'd0, expAbort});
    if (expWe) begin
      checkOutput("chunk_data", chunkData, expData);
      checkOutput("row_addr", {28'd0, rowAddr}, 32'(expRow));
      checkOutput("chunk_addr", {28'd0, chunkAddr}, 32'(expChunk));
    end
    if (logEnable && chunkWe) begin
      logData.push_back(chunkData);
      logRow.push_back(rowAddr);
      logChunk.push_back(chunkAddr);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_we"},    {31'd0, chunkWe}, 32'd0);
    checkOutput({tag, "_busy"},  {31'd0, busy}, 32'd0);
    checkOutput({tag, "_done"},  {31'd0, frameDone}, 32'd0);
    checkOutput({tag, "_abort"}, {31'd0, frameAbort}, 32'd0);
    checkOutput({tag, "_ready"}, {31'd0, byteReady}, 32'd0);
    checkOutput({tag, "_data"},  chunkData, 32'd0);
    checkOutput({tag, "_row"},   {28'd0, rowAddr}, 32'd0);
    checkOutput({tag, "_chunk"}, {28'd0, chunkAddr}, 32'd0);
  endtask

  initial begin
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    resetN = 1'b1;

    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 8'($urandom));

    logEnable = 1'b1;
    applyStimulus(1, 0, 8'd0);
    for (int i = 0; i < 768; i++) applyStimulus(0, 1, 8'(i));
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 8'($urandom));
    logEnable = 1'b0;
    checkOutput("full_write_count", 32'(logData.size()), 32'd192);
    if (logData.size() == 192) begin
      checkOutput("first_data", logData[0], 32'h00010203);
      checkOutput("first_row", {28'd0, logRow[0]}, 32'd0);
      checkOutput("first_chunk", {28'd0, logChunk[0]}, 32'd11);
      checkOutput("w13_data", logData[12], 32'h30313233);
      checkOutput("w13_row", {28'd0, logRow[12]}, 32'd1);
      checkOutput("w13_chunk", {28'd0, logChunk[12]}, 32'd11);
      checkOutput("last_data", logData[191], 32'hFCFDFEFF);
      checkOutput("last_row", {28'd0, logRow[191]}, 32'd15);
      checkOutput("last_chunk", {28'd0, logChunk[191]}, 32'd0);
    end

    applyStimulus(1, 0, 8'd0);
    for (int i = 0; i < 64; i++) applyStimulus(0, (i % 2) == 0, 8'($urandom));

    applyStimulus(1, 0, 8'd0);
    for (int i = 0; i < 100; i++) applyStimulus(0, 1, 8'($urandom));
    applyStimulus(1, 0, 8'd0);
    for (int i = 0; i < 768; i++) applyStimulus(0, 1, 8'($urandom));
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 8'd0);

    applyStimulus(1, 0, 8'd0);
    for (int i = 0; i < 7; i++) applyStimulus(0, 1, 8'($urandom));
    applyStimulus(1, 1, 8'hA5);
    checkOutput("restart_row", {28'd0, rowAddr}, 32'd0);
    checkOutput("restart_chunk", {28'd0, chunkAddr}, 32'd11);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 8'($urandom));

    applyStimulus(1, 0, 8'd0);
    applyStimulus(0, 1, 8'h11);
    applyStimulus(0, 1, 8'h22);
    frameStart = 1'b0; byteValid = 1'b0;
    #2 resetN = 1'b0;
    #1 checkAllZero("async_reset");
    modelReset();
    @(posedge clk);
    #1 resetN = 1'b1;
    applyStimulus(1, 0, 8'd0);
    for (int i = 0; i < 12; i++) applyStimulus(0, 1, 8'($urandom));

    applyStimulus(1, 0, 8'd0);
    for (int i = 0; i < 4000; i++)
      applyStimulus($urandom_range(0, 1499) == 0, $urandom_range(0, 3) != 0, 8'($urandom));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
